// File: rtl/uart_tx_framer.sv
// UART transmitter: one byte per valid/ready handshake, framed as start, 8 data bits LSB first,
// optional parity and 1 or 2 stop bits on a registered TxD that idles high.
//
// state  | meaning
// IDLE   | line high, tx_ready=1, waiting for a byte
// START  | driving the start bit (0)
// DATA   | shifting out D0..D7, LSB first
// PARITY | driving the parity bit (only reached when PARITY_EN=1)
// STOP   | driving 1 or 2 stop bits (1)
module uart_tx_framer #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 9_600,
   parameter int BIT_CYCLES = CLK_FREQ / BAUD_RATE,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0,
   parameter int STOP_BITS  = 1
) (
   input  logic       clk_fpga,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       TxD
);

   localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYCLES - 1);
   localparam logic STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic          stop_q, stop_d;
   logic [7:0]    data_q, data_d;
   logic          par_q, par_d;
   logic          txd_q, txd_d;
   logic          done_q, done_d;
   logic          baud_wrap;

   always_ff @(posedge clk_fpga or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         data_q  <= '0;
         par_q   <= 1'b0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         data_q  <= data_d;
         par_q   <= par_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
      end
   end

   assign baud_wrap = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      data_d  = data_q;
      par_d   = par_q;
      txd_d   = txd_q;
      done_d  = 1'b0;

      if (state_q != IDLE) begin
         baud_d = baud_wrap ? '0 : baud_q + 1'b1;
      end

      // txd_d is the value TxD will hold after the coming edge, so each branch
      // selects the level of the bit being entered.
      case (state_q)
         IDLE: begin
            txd_d = 1'b1;
            if (tx_valid) begin
               state_d = START;
               txd_d   = 1'b0;
               baud_d  = '0;
               bit_d   = '0;
               stop_d  = 1'b0;
               data_d  = tx_data;
               par_d   = (^tx_data) ^ PARITY_ODD;
            end
         end
         START: begin
            if (baud_wrap) begin
               state_d = DATA;
               txd_d   = data_q[0];
               data_d  = {1'b0, data_q[7:1]};
            end
         end
         DATA: begin
            if (baud_wrap) begin
               if (bit_q == 3'd7) begin
                  if (PARITY_EN) begin
                     state_d = PARITY;
                     txd_d   = par_q;
                  end else begin
                     state_d = STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_d  = bit_q + 3'd1;
                  txd_d  = data_q[0];
                  data_d = {1'b0, data_q[7:1]};
               end
            end
         end
         PARITY: begin
            if (baud_wrap) begin
               state_d = STOP;
               txd_d   = 1'b1;
            end
         end
         STOP: begin
            txd_d = 1'b1;
            if (baud_wrap) begin
               if (stop_q == STOP_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

   assign tx_ready = (state_q == IDLE);
   assign tx_busy  = ~tx_ready;
   assign tx_done  = done_q;
   assign TxD      = txd_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three configurations at 10 clocks/bit, line checked cycle by cycle
// against frames built from the byte, parity and stop-bit rules.
module tb_uart_tx_framer;

   localparam int BC = 10;
   localparam int PEN[3]   = '{0, 1, 1};
   localparam int PODD[3]  = '{0, 0, 1};
   localparam int STOPB[3] = '{1, 2, 1};

   logic       clk_fpga = 1'b0;
   logic       reset;
   logic [2:0] tx_valid;
   logic [7:0] tx_data [3];
   wire  [2:0] tx_ready, tx_busy, tx_done, txd;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk_fpga = ~clk_fpga;

   uart_tx_framer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1'b0),
                    .PARITY_ODD(1'b0), .STOP_BITS(1)) u0 (
      .clk_fpga(clk_fpga), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .TxD(txd[0]));

   uart_tx_framer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1'b1),
                    .PARITY_ODD(1'b0), .STOP_BITS(2)) u1 (
      .clk_fpga(clk_fpga), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .TxD(txd[1]));

   uart_tx_framer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1'b1),
                    .PARITY_ODD(1'b1), .STOP_BITS(1)) u2 (
      .clk_fpga(clk_fpga), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .TxD(txd[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int frame_len(input int idx);
      return 10 + PEN[idx] + STOPB[idx] - 1;
   endfunction

   // Line level of frame bit b: start, D0..D7, optional parity, then stop bits.
   function automatic logic frame_bit(input int idx, input logic [7:0] d, input int b);
      int ones;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (PEN[idx] == 1 && b == 9) begin
         ones = 0;
         for (int i = 0; i < 8; i++) ones += int'(d[i]);
         return ((ones % 2) == 1) ^ (PODD[idx] == 1);
      end
      return 1'b1;
   endfunction

   task automatic accept(input int idx, input logic [7:0] d);
      int t = 0;
      while (!tx_ready[idx] && t < 200) begin
         @(posedge clk_fpga); #1;
         t++;
      end
      chk("ready_wait", 32'(tx_ready[idx]), 32'd1);
      tx_valid[idx] = 1'b1;
      tx_data[idx]  = d;
      @(posedge clk_fpga); #1;
   endtask

   // Entered 1ns after the accept edge; leaves 1ns after the edge that raises tx_done.
   task automatic check_frame(input int idx, input logic [7:0] d, input bit hold,
                              input logic [7:0] nxt, input int pulse_k);
      int n = frame_len(idx);
      for (int k = 0; k < n * BC; k++) begin
         chk($sformatf("txd%0d_d%02h_bit%0d", idx, d, k / BC), 32'(txd[idx]),
             32'(frame_bit(idx, d, k / BC)));
         chk($sformatf("done%0d_early", idx), 32'(tx_done[idx]), 32'd0);
         if (k % BC == 0) begin
            chk($sformatf("busy%0d", idx), 32'(tx_busy[idx]), 32'd1);
            chk($sformatf("ready%0d", idx), 32'(tx_ready[idx]), 32'd0);
         end
         if (k == 0) begin
            if (hold) tx_data[idx] = nxt;
            else begin
               tx_valid[idx] = 1'b0;
               tx_data[idx]  = 8'($urandom);
            end
         end
         if (pulse_k > 0 && k == pulse_k) begin
            tx_valid[idx] = 1'b1;
            tx_data[idx]  = 8'($urandom);
         end
         if (pulse_k > 0 && k == pulse_k + 1) tx_valid[idx] = 1'b0;
         @(posedge clk_fpga); #1;
      end
      chk($sformatf("done%0d_pulse", idx), 32'(tx_done[idx]), 32'd1);
      chk($sformatf("ready%0d_end", idx), 32'(tx_ready[idx]), 32'd1);
      chk($sformatf("busy%0d_end", idx), 32'(tx_busy[idx]), 32'd0);
      chk($sformatf("txd%0d_end", idx), 32'(txd[idx]), 32'd1);
   endtask

   task automatic post_idle(input int idx);
      @(posedge clk_fpga); #1;
      chk($sformatf("done%0d_one_cycle", idx), 32'(tx_done[idx]), 32'd0);
      chk($sformatf("ready%0d_idle", idx), 32'(tx_ready[idx]), 32'd1);
      chk($sformatf("txd%0d_idle", idx), 32'(txd[idx]), 32'd1);
   endtask

   task automatic send(input int idx, input logic [7:0] d, input int pulse_k);
      accept(idx, d);
      check_frame(idx, d, 1'b0, 8'h00, pulse_k);
      post_idle(idx);
   endtask

   initial begin
      logic [7:0] lb [4];
      logic [7:0] r;
      lb = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
      reset    = 1'b0;
      tx_valid = 3'b001;
      for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
      tx_data[0] = 8'hC3;

      for (int i = 0; i < 5; i++) begin
         @(posedge clk_fpga); #1;
         chk("rst_txd", 32'(txd), 32'h7);
         chk("rst_ready", 32'(tx_ready), 32'h7);
         chk("rst_busy", 32'(tx_busy), 32'h0);
         chk("rst_done", 32'(tx_done), 32'h0);
      end
      @(negedge clk_fpga) reset = 1'b1;
      @(posedge clk_fpga); #1;
      check_frame(0, 8'hC3, 1'b0, 8'h00, 0);
      post_idle(0);

      send(0, 8'h55, 37);
      send(1, 8'h07, 55);
      send(2, 8'h07, 0);

      accept(1, 8'hA3);
      check_frame(1, 8'hA3, 1'b1, 8'h3C, 0);
      @(posedge clk_fpga); #1;
      check_frame(1, 8'h3C, 1'b0, 8'h00, 0);
      post_idle(1);

      accept(0, 8'h00);
      tx_valid[0] = 1'b0;
      for (int k = 0; k < 4 * BC + 3; k++) begin
         @(posedge clk_fpga); #1;
      end
      chk("abort_pre_txd", 32'(txd[0]), 32'd0);
      #3 reset = 1'b0;
      #1;
      chk("abort_async_txd", 32'(txd[0]), 32'd1);
      chk("abort_ready", 32'(tx_ready[0]), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_fpga); #1;
         chk("abort_no_done", 32'(tx_done), 32'h0);
      end
      @(negedge clk_fpga) reset = 1'b1;
      @(posedge clk_fpga); #1;
      chk("abort_no_done_rel", 32'(tx_done), 32'h0);
      chk("abort_txd_rel", 32'(txd), 32'h7);
      r = 8'($urandom);
      send(0, r, 0);

      for (int idx = 0; idx < 3; idx++)
         for (int i = 0; i < 4; i++) send(idx, lb[i], 0);

      for (int idx = 0; idx < 3; idx++)
         for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            send(idx, r, int'($urandom_range(5, 90)));
         end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
